lockable_bank_programmer: RTL and testbench

- Initiator side of the lockable-register interface.
- Accepts configuration write and commit requests over a valid/ready port.
- Drives per-register write enables and shared data into a bank of NUM_REGS lockable registers, and verifies each write by reading it back.
- On commit, asserts the bank-wide lock; from then until reset, every further write is refused and reported as an error.

---
 rtl/lock_prog_pkg.sv | 20 ++
 rtl/lock_prog_verify.sv | 31 +++
 rtl/lockable_bank_programmer.sv | 166 ++++++++++++++++
 tb/tb_lockable_bank_programmer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_prog_pkg.sv
// lock_prog_pkg: shared types and constants for the lockable bank programmer.
//   state_e   - controller state encoding (IDLE, WRITE, VERIFY, LOCK, LOCKED)
//   RSP_OK / RSP_ERR - response status values carried on rsp_err
//   ERR_CNT_W - width of the saturating error counter
package lock_prog_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_VERIFY = 3'd2,
      ST_LOCK   = 3'd3,
      ST_LOCKED = 3'd4
   } state_e;

   localparam logic RSP_OK  = 1'b0;
   localparam logic RSP_ERR = 1'b1;

   localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/lock_prog_verify.sv
// lock_prog_verify: selects one register's readback slice from the
// concatenated bank bus and compares it against the expected write data.
// Ports:
//   rd_data_i - NUM_REGS*DATA_W concatenated readback, reg i at [i*DATA_W +: DATA_W]
//   sel_i     - register index to check
//   exp_i     - expected data
//   match_o   - 1 when the selected readback equals exp_i
module lock_prog_verify #(
   parameter  int NUM_REGS = 4,
   parameter  int DATA_W   = 8,
   localparam int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic [NUM_REGS*DATA_W-1:0] rd_data_i,
   input  logic [SEL_W-1:0]           sel_i,
   input  logic [DATA_W-1:0]          exp_i,
   output logic                       match_o
);

   logic [DATA_W-1:0] rd_sel;

   // Loop mux keeps every slice index constant and in range.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sel_i == SEL_W'(i)) rd_sel = rd_data_i[i*DATA_W +: DATA_W];
      end
   end

   assign match_o = (rd_sel == exp_i);

endmodule

// File: rtl/lockable_bank_programmer.sv
// lockable_bank_programmer: initiator for a bank of NUM_REGS lockable
// registers. Takes write/commit requests on a valid/ready port, drives a
// one-hot write enable plus shared data, optionally verifies each write by
// readback, and on commit raises the bank-wide lock until reset.
// Build option: define LOCK_PROG_READBACK_VERIFY_EN to add the VERIFY state
// (write response in cycle 3 with mismatch status); otherwise writes answer
// cleanly in cycle 2 and reg_rd_data is ignored.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   req_valid/req_ready   - request handshake
//   req_commit            - 1 = lock command, 0 = write of req_data to req_addr
//   rsp_valid/rsp_err     - one-cycle response pulse and status
//   reg_wr_en, reg_data   - one-hot write enables and shared write data
//   reg_lock_en           - broadcast lock, held from commit until reset
//   reg_rd_data           - concatenated readback buses
//   locked, err_count     - commit done; saturating error response count
module lockable_bank_programmer
   import lock_prog_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 2,
   parameter int DATA_W   = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_commit,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [DATA_W-1:0]          req_data,
   output logic                       rsp_valid,
   output logic                       rsp_err,
   output logic [NUM_REGS-1:0]        reg_wr_en,
   output logic [DATA_W-1:0]          reg_data,
   output logic                       reg_lock_en,
   input  logic [NUM_REGS*DATA_W-1:0] reg_rd_data,
   output logic                       locked,
   output logic [ERR_CNT_W-1:0]       err_count
);

   localparam logic [ADDR_W:0] NREGS_CMP = (ADDR_W+1)'(NUM_REGS);

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic                   rsp_err_q, rsp_err_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic                   in_range;

   assign in_range = ({1'b0, req_addr} < NREGS_CMP);

`ifdef LOCK_PROG_READBACK_VERIFY_EN
   localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   logic rd_match;

   lock_prog_verify #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W)
   ) u_verify (
      .rd_data_i (reg_rd_data),
      .sel_i     (addr_q[SEL_W-1:0]),
      .exp_i     (data_q),
      .match_o   (rd_match)
   );
`else
   logic unused_rd;
   assign unused_rd = ^reg_rd_data;
`endif

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= RSP_OK;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // Next state. Responses are registered, so the pulse appears in the cycle
   // after the transition that decides it.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = RSP_OK;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_commit) begin
                  state_d = ST_LOCK;
               end else if (in_range) begin
                  state_d = ST_WRITE;
                  addr_d  = req_addr;
                  data_d  = req_data;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = RSP_ERR;
               end
            end
         end
         ST_WRITE: begin
`ifdef LOCK_PROG_READBACK_VERIFY_EN
            state_d = ST_VERIFY;
`else
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
`endif
         end
         ST_VERIFY: begin
            state_d = ST_IDLE;
`ifdef LOCK_PROG_READBACK_VERIFY_EN
            rsp_valid_d = 1'b1;
            rsp_err_d   = rd_match ? RSP_OK : RSP_ERR;
`endif
         end
         ST_LOCK: begin
            state_d     = ST_LOCKED;
            rsp_valid_d = 1'b1;
         end
         ST_LOCKED: begin
            // Locked bank: writes are refused, repeat commits are harmless.
            if (req_valid) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = req_commit ? RSP_OK : RSP_ERR;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Counter moves with the response it counts.
      err_cnt_d = err_cnt_q;
      if (rsp_valid_d && (rsp_err_d == RSP_ERR) && (err_cnt_q != '1))
         err_cnt_d = err_cnt_q + 1'b1;
   end

   // Outputs.
   always_comb begin
      req_ready   = (state_q == ST_IDLE) || (state_q == ST_LOCKED);
      reg_lock_en = (state_q == ST_LOCK) || (state_q == ST_LOCKED);
      locked      = (state_q == ST_LOCKED);
      reg_wr_en   = '0;
      if (state_q == ST_WRITE) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) reg_wr_en[i] = 1'b1;
         end
      end
   end

   assign reg_data  = data_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_lockable_bank_programmer.sv
// Testbench for lockable_bank_programmer with NUM_REGS = 3 (so address 3 is
// out of range). A small target bank answers reg_wr_en/reg_data and can be
// forced to read back zero. Expectations come from a transaction-level model
// of latency, status, error count and lock state.
module tb_lockable_bank_programmer;

   localparam int NR = 3;
   localparam int AW = 2;
   localparam int DW = 8;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic             req_commit;
   logic [AW-1:0]    req_addr;
   logic [DW-1:0]    req_data;
   logic             rsp_valid;
   logic             rsp_err;
   logic [NR-1:0]    reg_wr_en;
   logic [DW-1:0]    reg_data;
   logic             reg_lock_en;
   logic [NR*DW-1:0] reg_rd_data;
   logic             locked;
   logic [7:0]       err_count;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] bank [NR];
   bit            corrupt;

   bit            m_locked;
   int            m_err;
   logic [DW-1:0] m_data;

   lockable_bank_programmer #(
      .NUM_REGS (NR),
      .ADDR_W   (AW),
      .DATA_W   (DW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_commit  (req_commit),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .rsp_valid   (rsp_valid),
      .rsp_err     (rsp_err),
      .reg_wr_en   (reg_wr_en),
      .reg_data    (reg_data),
      .reg_lock_en (reg_lock_en),
      .reg_rd_data (reg_rd_data),
      .locked      (locked),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Target bank: registers capture reg_data on their write enable.
   initial for (int i = 0; i < NR; i++) bank[i] = '0;
   always @(posedge clk) begin
      for (int i = 0; i < NR; i++) if (reg_wr_en[i]) bank[i] <= reg_data;
   end
   always_comb begin
      reg_rd_data = '0;
      for (int i = 0; i < NR; i++) if (!corrupt) reg_rd_data[i*DW +: DW] = bank[i];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) check("wr_en_onehot", 32'($countones(reg_wr_en) <= 1), 32'd1);

   // One request from a negedge; returns at the negedge of its response pulse.
   task automatic do_req(input bit cmt, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit bad);
      int            lat;
      int            got;
      bit            e;
      bit            lk;
      logic [NR-1:0] wen;
      wen = '0;
      if (m_locked) begin
         lat = 1; e = !cmt; lk = 1'b1;
      end else if (cmt) begin
         lat = 2; e = 1'b0; lk = 1'b1;
      end else if (int'(a) >= NR) begin
         lat = 1; e = 1'b1; lk = 1'b0;
      end else begin
         lk = 1'b0;
         wen[a] = 1'b1;
`ifdef LOCK_PROG_READBACK_VERIFY_EN
         lat = 3; e = bad;
`else
         lat = 2; e = 1'b0;
`endif
      end
      check("ready_before_req", 32'(req_ready), 32'd1);
      corrupt    = bad;
      req_valid  = 1'b1;
      req_commit = cmt;
      req_addr   = a;
      req_data   = d;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_commit = 1'($urandom);
      req_addr   = AW'($urandom);
      req_data   = DW'($urandom);
      got = 0;
      for (int c = 1; c <= 6 && got == 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check("wr_en_c1", 32'(reg_wr_en), 32'(wen));
            check("lock_en_c1", 32'(reg_lock_en), 32'(lk));
            check("locked_c1", 32'(locked), 32'(m_locked));
            if (wen != '0) check("reg_data_c1", 32'(reg_data), 32'(d));
         end
         if (rsp_valid) got = c;
      end
      check("rsp_latency", 32'(got), 32'(lat));
      if (got != 0) check("rsp_err", 32'(rsp_err), 32'(e));
      if (e && m_err < 255) m_err++;
      if (cmt) m_locked = 1'b1;
      if (wen != '0) m_data = d;
      check("err_count", 32'(err_count), 32'(m_err));
      check("locked", 32'(locked), 32'(m_locked));
      check("reg_data_hold", 32'(reg_data), 32'(m_data));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},   32'(req_ready),   32'd1);
      check({tag, "_rsp"},     32'(rsp_valid),   32'd0);
      check({tag, "_rsp_err"}, 32'(rsp_err),     32'd0);
      check({tag, "_wr_en"},   32'(reg_wr_en),   32'd0);
      check({tag, "_data"},    32'(reg_data),    32'd0);
      check({tag, "_lock_en"}, 32'(reg_lock_en), 32'd0);
      check({tag, "_locked"},  32'(locked),      32'd0);
      check({tag, "_errcnt"},  32'(err_count),   32'd0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_commit = 1'b0;
      req_addr = '0; req_data = '0; corrupt = 1'b0;
      m_locked = 1'b0; m_err = 0; m_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed writes: clean, readback mismatch, out of range.
      do_req(1'b0, 2'd2, 8'hA5, 1'b0);
      do_req(1'b0, 2'd1, 8'h3C, 1'b1);
      do_req(1'b0, 2'd3, 8'h11, 1'b0);
      do_req(1'b0, 2'd0, 8'h77, 1'b0);

      // Reset while the write to address 0 is in flight.
      corrupt = 1'b0;
      req_valid = 1'b1; req_commit = 1'b0; req_addr = 2'd0; req_data = 8'h5A;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("abort_wr_en", 32'(reg_wr_en), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("abort");
      rst_n = 1'b1;
      m_err = 0; m_locked = 1'b0; m_data = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("abort_no_rsp", 32'(rsp_valid), 32'd0);
         check("abort_ready", 32'(req_ready), 32'd1);
      end

      // Random unlocked traffic, back to back.
      for (int k = 0; k < 40; k++)
         do_req(1'b0, AW'($urandom_range(0, 3)), DW'($urandom), 1'($urandom_range(0, 1)));

      // Commit, refused write, repeat commit.
      do_req(1'b1, AW'($urandom), DW'($urandom), 1'b0);
      do_req(1'b0, 2'd0, 8'hFF, 1'b0);
      do_req(1'b1, 2'd2, 8'h00, 1'b0);
      check("lock_en_held", 32'(reg_lock_en), 32'd1);

      // Saturate the error counter.
      for (int k = 0; k < 260; k++)
         do_req(1'b0, AW'($urandom_range(0, 3)), DW'($urandom), 1'b0);
      check("err_sat", 32'(err_count), 32'd255);

      // Reset releases the lock.
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("final_lock_en", 32'(reg_lock_en), 32'd0);
      check("final_locked", 32'(locked), 32'd0);
      check("final_errcnt", 32'(err_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
